// File: rtl/plot_sweep_ctrl_pkg.sv
// Shared constants for the plot sweep controller: state encoding and speed indices.
// States are plain localparam codes so older benches can compare raw values.
package plot_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
   localparam logic [STATE_W-1:0] ST_EMIT  = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

   localparam logic [1:0] SPD_IDX0 = 2'd0;
   localparam logic [1:0] SPD_IDX1 = 2'd1;
   localparam logic [1:0] SPD_IDX2 = 2'd2;
   localparam logic [1:0] SPD_IDX3 = 2'd3;

   function automatic logic [31:0] spd_select(
      input logic [1:0]  sel,
      input logic [31:0] s0,
      input logic [31:0] s1,
      input logic [31:0] s2,
      input logic [31:0] s3
   );
      logic [31:0] v;
      case (sel)
         SPD_IDX0: v = s0;
         SPD_IDX1: v = s1;
         SPD_IDX2: v = s2;
         default:  v = s3;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/plot_sweep_ctrl.sv
// Sweep controller: steps x from 0 to X_MAX, pacing each step off an external
// down-counter and handing each column to the plotter with a valid/ready handshake.
module plot_sweep_ctrl
   import plot_pkg::*;
#(
   parameter int unsigned X_MAX = 159,
   parameter logic [31:0] SPD0  = 32'd49_999_999,
   parameter logic [31:0] SPD1  = 32'd4_999_999,
   parameter logic [31:0] SPD2  = 32'd499_999,
   parameter logic [31:0] SPD3  = 32'd49_999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        pause,
   input  logic [1:0]  speed,
   input  logic [31:0] div_count,
   input  logic        x_ready,
   output logic [31:0] div_start_val,
   output logic        div_enable,
   output logic        div_reset_n,
   output logic [7:0]  x,
   output logic        x_valid,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] X_LAST = 8'(X_MAX);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic [7:0]         r_x;
   logic [31:0]        r_div_start_val;
   logic               w_tick;
   logic               w_launch;
   logic               w_step;

   assign w_tick   = (div_count == '0);
   assign w_launch = (r_state == ST_IDLE) && start && !abort;
   assign w_step   = (r_state == ST_EMIT) && x_ready && !abort;

   always_comb begin
      w_state_nxt = r_state;
      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_launch) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_WAIT;
            // a tick in the same cycle as pause still emits
            ST_WAIT: begin
               if (w_tick)     w_state_nxt = ST_EMIT;
               else if (pause) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (!pause) w_state_nxt = ST_WAIT;
            ST_EMIT: begin
               if (x_ready) w_state_nxt = (r_x == X_LAST) ? ST_DONE : ST_WAIT;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_x             <= '0;
         r_div_start_val <= SPD0;
      end else begin
         r_state <= w_state_nxt;
         if (w_launch) begin
            r_div_start_val <= spd_select(speed, SPD0, SPD1, SPD2, SPD3);
            r_x             <= '0;
         end else if (w_step && (r_x != X_LAST)) begin
            r_x <= r_x + 8'd1;
         end
      end
   end

   // every output is either a register or a pure decode of r_state
   assign div_start_val = r_div_start_val;
   assign x             = r_x;
   assign x_valid       = (r_state == ST_EMIT);
   assign div_enable    = (r_state == ST_WAIT);
   assign div_reset_n   = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_plot_sweep_ctrl.sv
// Directed bench for plot_sweep_ctrl with a behavioural external down-counter.
module tb_plot_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        pause;
   logic [1:0]  speed;
   logic [31:0] div_count;
   logic        x_ready;
   logic [31:0] div_start_val;
   logic        div_enable;
   logic        div_reset_n;
   logic [7:0]  x;
   logic        x_valid;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int snap;
   logic [31:0] cnt = '0;

   plot_sweep_ctrl #(
      .X_MAX(3),
      .SPD0(32'd3),
      .SPD1(32'd5),
      .SPD2(32'd2),
      .SPD3(32'd1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .pause(pause),
      .speed(speed),
      .div_count(div_count),
      .x_ready(x_ready),
      .div_start_val(div_start_val),
      .div_enable(div_enable),
      .div_reset_n(div_reset_n),
      .x(x),
      .x_valid(x_valid),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // external down-counter: sync reset, reload when disabled, count down to 0
   always @(posedge clk) begin
      if (!div_reset_n)     cnt <= '0;
      else if (!div_enable) cnt <= div_start_val;
      else if (cnt != 0)    cnt <= cnt - 32'd1;
   end
   assign div_count = cnt;

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   typedef struct {
      logic [3:0]  in;   // {start, abort, pause, x_ready}
      logic [12:0] exp;  // {x_valid, x, busy, done, div_enable, div_reset_n}
   } vec_t;

   vec_t vecs[24];
   logic [31:0] spd_exp[4];

   function automatic logic [12:0] pk(int v, int xv, int b, int d, int e, int r);
      return {v[0], xv[7:0], b[0], d[0], e[0], r[0]};
   endfunction

   function automatic logic [12:0] outs();
      return {x_valid, x, busy, done, div_enable, div_reset_n};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_x(input int target, input int budget);
      int n;
      n = 0;
      while (!(x_valid && (x == 8'(target))) && (n < budget)) begin
         step();
         n++;
      end
      chk("wait_x_reached", {63'd0, (x_valid && (x == 8'(target)))}, 64'd1);
   endtask

   initial begin
      vecs[0]  = '{4'b1001, pk(0,0,1,0,0,1)};
      vecs[1]  = '{4'b0001, pk(0,0,1,0,1,1)};
      vecs[2]  = '{4'b0001, pk(0,0,1,0,1,1)};
      vecs[3]  = '{4'b0001, pk(0,0,1,0,1,1)};
      vecs[4]  = '{4'b0001, pk(0,0,1,0,1,1)};
      vecs[5]  = '{4'b0001, pk(1,0,1,0,0,1)};
      vecs[6]  = '{4'b0001, pk(0,1,1,0,1,1)};
      vecs[7]  = '{4'b0001, pk(0,1,1,0,1,1)};
      vecs[8]  = '{4'b0001, pk(0,1,1,0,1,1)};
      vecs[9]  = '{4'b0001, pk(0,1,1,0,1,1)};
      vecs[10] = '{4'b0001, pk(1,1,1,0,0,1)};
      vecs[11] = '{4'b0001, pk(0,2,1,0,1,1)};
      vecs[12] = '{4'b0001, pk(0,2,1,0,1,1)};
      vecs[13] = '{4'b0001, pk(0,2,1,0,1,1)};
      vecs[14] = '{4'b0001, pk(0,2,1,0,1,1)};
      vecs[15] = '{4'b0001, pk(1,2,1,0,0,1)};
      vecs[16] = '{4'b0001, pk(0,3,1,0,1,1)};
      vecs[17] = '{4'b0001, pk(0,3,1,0,1,1)};
      vecs[18] = '{4'b0001, pk(0,3,1,0,1,1)};
      vecs[19] = '{4'b0001, pk(0,3,1,0,1,1)};
      vecs[20] = '{4'b0001, pk(1,3,1,0,0,1)};
      vecs[21] = '{4'b0001, pk(0,3,1,1,0,0)};
      vecs[22] = '{4'b0001, pk(0,3,0,0,0,0)};
      vecs[23] = '{4'b0001, pk(0,3,0,0,0,0)};
      spd_exp[0] = 32'd3;
      spd_exp[1] = 32'd5;
      spd_exp[2] = 32'd2;
      spd_exp[3] = 32'd1;

      reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
      speed = 2'd0; x_ready = 1'b1;
      step();
      step();
      chk("reset_outputs", {51'd0, outs()}, {51'd0, pk(0,0,0,0,0,0)});
      chk("reset_div_start_val", {32'd0, div_start_val}, 64'd3);
      reset = 1'b1;
      step();

      // full sweep, speed 0, x_ready high
      snap = done_cnt;
      for (int i = 0; i < 24; i++) begin
         {start, abort, pause, x_ready} = vecs[i].in;
         step();
         chk($sformatf("sweep_row%0d", i), {51'd0, outs()}, {51'd0, vecs[i].exp});
      end
      chk("sweep_done_once", 64'(done_cnt - snap), 64'd1);

      // speed latched at start
      for (int s = 0; s < 4; s++) begin
         speed = 2'(s);
         start = 1'b1;
         step();
         start = 1'b0;
         chk($sformatf("speed_latch%0d", s), {32'd0, div_start_val}, {32'd0, spd_exp[s]});
         abort = 1'b1;
         step();
         abort = 1'b0;
         chk("abort_idle", {63'd0, busy}, 64'd0);
      end

      // backpressure in EMIT
      speed = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_x(0, 20);
      x_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid_x", {55'd0, x_valid, x}, {55'd0, 1'b1, 8'd0});
      end
      x_ready = 1'b1;
      step();
      chk("stall_release", {54'd0, x_valid, x, div_enable}, {54'd0, 1'b0, 8'd1, 1'b1});
      abort = 1'b1;
      step();
      abort = 1'b0;

      // pause mid-WAIT, resume phase, tick beats pause, pause ignored in EMIT
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("pause_pre_wait", {63'd0, div_enable}, 64'd1);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("pause_no_valid", {62'd0, x_valid, div_enable}, 64'd0);
      end
      pause = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("resume_no_valid", {63'd0, x_valid}, 64'd0);
      end
      step();
      chk("resume_valid5", {55'd0, x_valid, x}, {55'd0, 1'b1, 8'd0});
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pre_tick_no_valid", {63'd0, x_valid}, 64'd0);
      end
      pause = 1'b1;
      step();
      chk("tick_beats_pause", {55'd0, x_valid, x}, {55'd0, 1'b1, 8'd1});
      step();
      chk("pause_ignored_emit", {54'd0, x_valid, x, div_enable}, {54'd0, 1'b0, 8'd2, 1'b1});
      step();
      chk("pause_enters", {62'd0, busy, div_enable}, {62'd0, 1'b1, 1'b0});
      pause = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;

      // abort at x=2
      snap = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_x(2, 60);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_outputs", {60'd0, busy, x_valid, div_reset_n, done}, 64'd0);
      step();
      step();
      chk("abort_no_done", 64'(done_cnt - snap), 64'd0);

      // start+abort together, start while busy
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", {63'd0, busy}, 64'd0);
      step();
      chk("start_abort_stays", {62'd0, busy, div_reset_n}, 64'd0);
      speed = 2'd0;
      start = 1'b1;
      step();
      speed = 2'd1;
      step();
      start = 1'b0;
      chk("busy_start_ignored", {30'd0, div_start_val, busy, div_enable}, {30'd0, 32'd3, 1'b1, 1'b1});
      for (int i = 0; i < 3; i++) begin
         step();
         chk("busy_start_no_valid", {63'd0, x_valid}, 64'd0);
      end
      step();
      chk("busy_start_timing", {55'd0, x_valid, x}, {55'd0, 1'b1, 8'd0});
      abort = 1'b1;
      step();
      abort = 1'b0;

      // reset mid-sweep
      snap = done_cnt;
      speed = 2'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_x(1, 40);
      reset = 1'b0;
      step();
      chk("midreset_outputs", {51'd0, outs()}, {51'd0, pk(0,0,0,0,0,0)});
      chk("midreset_div_start_val", {32'd0, div_start_val}, 64'd3);
      reset = 1'b1;
      step();
      chk("midreset_idle", {62'd0, busy, div_reset_n}, 64'd0);
      chk("midreset_no_done", 64'(done_cnt - snap), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
